pc_sequencer: RTL and testbench

Fetch-side program counter sequencer for the 5-stage pipeline. It is the consumer of branch targets produced by the EX-stage branch target adder. It holds the fetch PC and advances it by 4 each cycle. It accepts taken-branch redirects, holds under hazard stall, and emits a one-cycle flush plus a configurable number of fetch bubbles after each redirect.

---
 rtl/pc_sequencer_pkg.sv | 12 +
 rtl/pc_sequencer_if.sv | 24 ++
 rtl/pc_sequencer_next_sel.sv | 29 ++
 rtl/pc_sequencer.sv | 94 +++++++++
 tb/tb_pc_sequencer.sv | 125 ++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared pipeline types for the fetch-side PC sequencer.
// Holds the sequencer state enum and the address/instruction widths.
package cpu_pkg;
  localparam int ADDR_W = 64;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    RUN,
    BUBBLE,
    HALT
  } pc_state_e;
endpackage

// File: rtl/pc_sequencer_if.sv
// Branch-resolve inputs and fetch outputs of the PC sequencer.
// master drives branches/stall, slave is the sequencer itself.
interface pc_sequencer_if;
  import cpu_pkg::*;

  logic              stall;
  logic              br_valid;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] fetch_pc;
  logic              fetch_valid;
  logic              flush;
  logic              misalign;

  modport master (
    output stall, br_valid, br_taken, br_target,
    input  fetch_pc, fetch_valid, flush, misalign
  );

  modport slave (
    input  stall, br_valid, br_taken, br_target,
    output fetch_pc, fetch_valid, flush, misalign
  );
endinterface

// File: rtl/pc_sequencer_next_sel.sv
// Next-PC priority mux: reset > redirect > stall > hold > PC+4.
// The +4 incrementer wraps modulo 2^64 without any flag.
module pc_next_sel
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              reset,
  input  logic              redirect,
  input  logic              stall,
  input  logic              hold,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] next_pc
);
  logic [ADDR_W-1:0] inc;

  assign inc = pc + ADDR_W'(INSTR_BYTES);

  always_comb begin
    next_pc = inc;
    if (reset)
      next_pc = RESET_PC;
    else if (redirect)
      next_pc = target;
    else if (stall || hold)
      next_pc = pc;
  end
endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: redirects, stall hold, flush pulse, fetch bubbles.
// Optional PC_MISALIGN_CHECK_EN halts on a misaligned branch target.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0,
  parameter int unsigned REDIRECT_BUBBLES = 1
) (
  input  logic clk,
  input  logic reset,
  pc_sequencer_if.slave bus
);
  localparam logic [2:0] BUB = 3'(REDIRECT_BUBBLES);

  pc_state_e         state, state_d;
  logic [2:0]        cnt, cnt_d;
  logic [ADDR_W-1:0] pc, pc_d, tgt;
  logic              flush_q, flush_d;
  logic              redirect, halted;
  logic              mis_q, mis_d;

`ifdef PC_MISALIGN_CHECK_EN
  logic bad;
  assign tgt = bus.br_target;
  assign bad = |bus.br_target[1:0];
`else
  logic unused_lsb;
  assign unused_lsb = ^bus.br_target[1:0];
  assign tgt = {bus.br_target[ADDR_W-1:2], 2'b00};
`endif

  assign halted = (state == HALT);
  assign redirect = bus.br_valid & bus.br_taken & ~halted;

  pc_next_sel #(.RESET_PC(RESET_PC)) u_next (
    .reset   (reset),
    .redirect(redirect),
    .stall   (bus.stall),
    .hold    (state != RUN),
    .pc      (pc),
    .target  (tgt),
    .next_pc (pc_d)
  );

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    flush_d = 1'b0;
    mis_d   = mis_q;
    if (redirect) begin
      flush_d = 1'b1;
      cnt_d   = BUB;
      state_d = (BUB != 3'd0) ? BUBBLE : RUN;
`ifdef PC_MISALIGN_CHECK_EN
      if (bad) begin
        state_d = HALT;
        cnt_d   = 3'd0;
        mis_d   = 1'b1;
      end
`endif
    end else if (state == BUBBLE) begin
      // counts down even under stall
      cnt_d = cnt - 3'd1;
      if (cnt == 3'd1)
        state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    pc <= pc_d;
    if (reset) begin
      state   <= RUN;
      cnt     <= 3'd0;
      flush_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      flush_q <= flush_d;
      mis_q   <= mis_d;
    end
  end

  assign bus.fetch_pc    = pc;
  assign bus.fetch_valid = (state == RUN);
  assign bus.flush       = flush_q;
`ifdef PC_MISALIGN_CHECK_EN
  assign bus.misalign = mis_q;
`else
  assign bus.misalign = 1'b0;
  logic unused_mis;
  assign unused_mis = mis_q;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed steps then random.
// Honours PC_MISALIGN_CHECK_EN in its reference model.
module tb_pc_sequencer;
  import cpu_pkg::*;

  localparam int unsigned BUB = 1;
  localparam logic [63:0] RPC = 64'h0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_sequencer_if bus ();

  pc_sequencer #(
    .RESET_PC(RPC),
    .REDIRECT_BUBBLES(BUB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  logic [63:0] m_pc;
  int          m_left;
  bit          m_halt, m_flush, m_mis;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic model_step(input bit rst, input bit st, input bit bv,
                            input bit bt, input logic [63:0] tgt);
    if (rst) begin
      m_pc = RPC; m_left = 0; m_halt = 0; m_flush = 0; m_mis = 0;
    end else if (m_halt) begin
      m_flush = 0;
    end else if (bv && bt) begin
      m_flush = 1;
      m_left = BUB;
`ifdef PC_MISALIGN_CHECK_EN
      m_pc = tgt;
      if (tgt % 4 != 0) begin
        m_halt = 1; m_mis = 1; m_left = 0;
      end
`else
      m_pc = tgt - (tgt % 4);
`endif
    end else begin
      m_flush = 0;
      if (m_left > 0) m_left--;
      else if (!st) m_pc = m_pc + 64'd4;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("fetch_pc", bus.fetch_pc, m_pc);
    chk("fetch_valid", 64'(bus.fetch_valid), 64'(!m_halt && m_left == 0));
    chk("flush", 64'(bus.flush), 64'(m_flush));
    chk("misalign", 64'(bus.misalign), 64'(m_mis));
  endtask

  task automatic cyc(input bit rst, input bit st, input bit bv,
                     input bit bt, input logic [63:0] tgt);
    reset = rst;
    bus.stall = st;
    bus.br_valid = bv;
    bus.br_taken = bt;
    bus.br_target = tgt;
    @(posedge clk);
    model_step(rst, st, bv, bt, tgt);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [63:0] t;
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.br_valid = 1'b0;
    bus.br_taken = 1'b0;
    bus.br_target = '0;
    @(negedge clk);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 64'h100);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 64'h500);
    cyc(0, 1, 1, 1, 64'h200);
    cyc(0, 0, 1, 1, 64'h300);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 64'h102);
    cyc(0, 0, 1, 1, 64'h400);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 64'h800);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      t = {$urandom, $urandom};
      if ($urandom_range(0, 9) != 0) t[1:0] = 2'b00;
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1, t);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
